// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared FSM encodings and width helper for mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef logic [1:0] state_t;

  // Arbiter sequencer states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // Width of an encoded requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant.sv
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin grant. Searches req starting one
//                past last_ptr, wrapping modulo NUM_REQ, and returns the first
//                set bit as a one-hot grant plus its encoded index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  int   idx;
  logic found;

  // Rotating priority search; the requester just served has lowest priority
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_WIDTH'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter/sequencer sharing one single-port
//                valid/ready memory between NUM_REQ requesters. Each accepted
//                request drives the memory for one cycle, then waits for
//                ready (or a timeout) and returns a tagged response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
  output logic                          resp_valid_o,
  output logic [ID_WIDTH-1:0]           resp_id_o,
  output logic [WIDTH-1:0]              resp_rd_data_o,
  output logic                          resp_err_o,
  output logic                          busy_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wr_data_o,
  input  logic                          mem_ready_i,
  input  logic [WIDTH-1:0]              mem_rd_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [ID_WIDTH-1:0] last_ptr;
  logic [ID_WIDTH-1:0] cur_id;
  logic [CNT_W-1:0]    wait_cnt;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                accept;
  logic                resp_ok;
  logic                resp_timeout;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .req      (req_valid_i),
    .last_ptr (last_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is only offered in IDLE and never while reset is held, so no
  // transfer can be seen by a requester during reset
  assign req_ready_o  = (state == IDLE && rst) ? grant : '0;
  assign accept       = (state == IDLE) && (|grant);
  assign mem_valid_o  = (state == ISSUE);
  assign busy_o       = (state != IDLE);
  assign resp_ok      = (state == RESP) && mem_ready_i;
  assign resp_timeout = (state == RESP) && !mem_ready_i &&
                        (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Sequencer: IDLE -> ISSUE -> RESP -> IDLE, with round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_ptr <= ID_WIDTH'(NUM_REQ - 1);
      cur_id   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (accept) begin
            cur_id   <= grant_id;
            last_ptr <= grant_id;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= RESP;
        RESP: begin
          if (resp_ok || resp_timeout) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the granted requester's fields; they stay on the memory bus
  // until the next accept, qualified only by mem_valid_o
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wr_rd_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
    end else if (accept) begin
      mem_wr_rd_o   <= req_wr_rd_i[grant_id];
      mem_addr_o    <= req_addr_i[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wr_data_o <= req_wr_data_i[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  // Registered response: one-cycle pulse, fields held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_o   <= 1'b0;
      resp_id_o      <= '0;
      resp_rd_data_o <= '0;
      resp_err_o     <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      if (resp_ok) begin
        resp_valid_o   <= 1'b1;
        resp_id_o      <= cur_id;
        resp_rd_data_o <= mem_wr_rd_o ? '0 : mem_rd_data_i;
        resp_err_o     <= 1'b0;
      end else if (resp_timeout) begin
        resp_valid_o   <= 1'b1;
        resp_id_o      <= cur_id;
        resp_rd_data_o <= '0;
        resp_err_o     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares one single-port memory (valid/ready, registered read data, synchronous active-high reset) between NUM_REQ requesters. Each requester presents a one-transaction-at-a-time request; the arbiter grants, drives the memory for exactly one cycle, collects `ready`/read data, and returns a tagged response. It sits between the requesters and the memory. The memory's own reset is not driven by this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: memory data width.
- `DEPTH`, 16: memory depth.
- `ADDR_WIDTH`, $clog2(DEPTH): address width.
- `ID_WIDTH`, $clog2(NUM_REQ): requester-id width.
- `TIMEOUT`, 8: cycles waited in RESP for `mem_ready_i` before an error response; must be ≥ 1.
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  one-hot grant/accept.
- `req_wr_rd_i`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k.
- `req_wr_data_i`  in  NUM_REQ*WIDTH  packed write data; requester k occupies slice k.
- `resp_valid_o`  out  1  one-cycle response pulse.
- `resp_id_o`  out  ID_WIDTH  requester served.
- `resp_rd_data_o`  out  WIDTH  read data; 0 for writes and errors.
- `resp_err_o`  out  1  timeout flag, qualified by `resp_valid_o`.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `mem_valid_o`  out  1  to memory `valid`.
- `mem_wr_rd_o`  out  1  to memory `wr_rd`.
- `mem_addr_o`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wr_data_o`  out  WIDTH  to memory `wr_data`.
- `mem_ready_i`  in  1  from memory `ready`.
- `mem_rd_data_i`  in  WIDTH  from memory `rd_data`.

## Operation
- FSM states:
  - IDLE: if any `req_valid_i`, grant the first set bit searching from `last_ptr+1`, wrapping modulo NUM_REQ. Latch id, wr_rd, addr and data; set `last_ptr` = granted id; go to ISSUE.
  - ISSUE: `mem_valid_o` = 1 with the latched fields; go to RESP unconditionally.
  - RESP: `mem_valid_o` = 0.
    - If `mem_ready_i` = 1: register a response with `rd_data` = `mem_rd_data_i` for reads, 0 for writes, and `err` = 0; go to IDLE.
    - Otherwise increment the wait counter; when it reaches TIMEOUT, register a response with `err` = 1 and `rd_data` = 0; go to IDLE.
- `req_ready_o` is combinational: (state == IDLE) & grant one-hot. A transfer occurs at an edge where `req_valid_i[k]` & `req_ready_o[k]` are both 1.
- Requesters must hold their fields stable while `req_valid_i` is high and not yet accepted. Fields may change freely after acceptance.
- `last_ptr` resets to NUM_REQ-1, so requester 0 has priority after reset.
- A requester deasserting valid before grant is legal; no grant is issued to it.
- `mem_addr_o`, `mem_wr_rd_o` and `mem_wr_data_o` hold the latched values outside ISSUE. Only `mem_valid_o` qualifies them.
- Async reset mid-operation: FSM → IDLE, wait counter → 0, `last_ptr` → NUM_REQ-1, all outputs → 0. The in-flight transaction is dropped with no response.

## Timing
- Reset values: `req_ready_o`, `resp_valid_o`, `resp_id_o`, `resp_rd_data_o`, `resp_err_o`, `busy_o`, `mem_valid_o`, `mem_wr_rd_o`, `mem_addr_o` and `mem_wr_data_o` are all 0.
- With accept at edge E0: `mem_valid_o` is high from E0 to E1; the memory responds at E1; the response is registered at E2, so `resp_valid_o` is high from E2 to E3.
- Latency is 2 edges, accept to response.
- Throughput is one transaction per 3 cycles. The next accept can occur at E3, because the state is IDLE after E2.
- `mem_valid_o` is never high for two consecutive cycles. This guarantees the memory's `ready` drops at E2.
- Timeout response: registered at the edge where the wait counter reaches TIMEOUT, i.e. E1+TIMEOUT.

## Structure
- `mem_arb_pkg`:
  - state encodings IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  - id width helper.
- Sub-module `rr_grant`: combinational. Takes `req` [NUM_REQ] and `last_ptr` and produces a one-hot `grant` and an encoded `grant_id`. `last_ptr` and the FSM stay in the top level.
- The top level instantiates no memory. The bench wires it to the memory model.

## Test plan
- Single requester: req 2 writes addr 5 = 16'hA5A5, then reads addr 5. Expected:
  - `mem_valid_o` asserted for exactly 1 cycle per transaction;
  - read response has id 2 and data 16'hA5A5;
  - the write response has data 0.
- All 4 requesters hold valid continuously from reset. Grants occur in order 0,1,2,3,0 at 3-cycle spacing, and `resp_id_o` follows the same order.
- Requesters 1 and 3 active with `last_ptr` = 1: req 3 is granted first, then req 1 (wrap-around).
- Memory `ready` forced to 0 with TIMEOUT = 8: `resp_valid_o` with `err` = 1 and data 0 appears at E1+8, and the next request is then granted normally.
- `rst` asserted low during RESP: all outputs are 0 immediately and no response is emitted. After release, requester 0 wins when all are requesting.
- Requester 2 deasserts valid the cycle before it would be granted: the grant skips to the next active requester, and requester 2 receives no response.
